// File: rtl/fifo_prog.sv
// Synchronous single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, sticky error flags and selectable FWFT read mode.
module fifo_prog #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 128,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       err_clr,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("fifo_prog: DATA_WIDTH must be at least 1");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_prog: DEPTH must be a power of two and at least 4");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("fifo_prog: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_prog: AEMPTY_THRESH must be in 0..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("fifo_prog: FWFT must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_ok;
  logic                  rd_ok;

  // Status flags decode the registered count, so they lag an accepted op by one edge.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A pop frees a slot in the same edge, so a full FIFO still takes a write alongside it.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  // NOTE: the storage array has no reset; only pointers and count define validity,
  // which keeps it mappable to RAM.
  always_ff @(posedge clock) begin
    if (!reset && wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the acceptance rules above.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A new error in the clearing cycle wins over err_clr.
      overflow_q  <= (overflow_q  & ~err_clr) | (wr_en & ~wr_ok);
      underflow_q <= (underflow_q & ~err_clr) | (rd_en & ~rd_ok);
    end
  end

  if (FWFT == 1) begin : g_fwft
    // Head word is presented directly; forced to zero while empty so reset reads 0.
    assign data_out = empty ? '0 : mem[rd_ptr];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clock) begin
      if (reset) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= mem[rd_ptr];
      end
    end
    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_fifo_prog.sv
// Self-checking bench for fifo_prog: a registered-output and an FWFT instance
// share stimulus and are compared against a queue-based reference model.
module tb_fifo_prog;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int AET   = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en;
  logic          rd_en;
  logic          err_clr;
  logic [DW-1:0] data_in;

  logic [DW-1:0] dout0, dout1;
  logic          full0, empty0, af0, ae0, ov0, un0;
  logic          full1, empty1, af1, ae1, ov1, un1;
  logic [3:0]    cnt0, cnt1;

  always #5 clock = ~clock;

  fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFT),
              .AEMPTY_THRESH(AET), .FWFT(0)) u_reg (
    .clock(clock), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .err_clr(err_clr), .data_out(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ov0), .underflow(un0)
  );

  fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFT),
              .AEMPTY_THRESH(AET), .FWFT(1)) u_fwft (
    .clock(clock), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .err_clr(err_clr), .data_out(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ov1), .underflow(un1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: occupancy is the queue itself.
  logic [DW-1:0] q[$];
  logic          m_ov   = 1'b0;
  logic          m_un   = 1'b0;
  logic [DW-1:0] m_dreg = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic w, input logic r, input logic c,
                            input logic rs, input logic [DW-1:0] d);
    bit r_ok, w_ok;
    if (rs) begin
      q.delete();
      m_ov = 1'b0; m_un = 1'b0; m_dreg = '0;
    end else begin
      r_ok = r && (q.size() > 0);
      w_ok = w && ((q.size() < DEPTH) || r_ok);
      if (r_ok) m_dreg = q.pop_front();
      if (w_ok) q.push_back(d);
      m_ov = (m_ov && !c) || (w && !w_ok);
      m_un = (m_un && !c) || (r && !r_ok);
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    check("reg.count",        64'(cnt0),  64'(n));
    check("reg.full",         64'(full0), 64'(n == DEPTH));
    check("reg.empty",        64'(empty0), 64'(n == 0));
    check("reg.almost_full",  64'(af0),   64'(n >= AFT));
    check("reg.almost_empty", 64'(ae0),   64'(n <= AET));
    check("reg.overflow",     64'(ov0),   64'(m_ov));
    check("reg.underflow",    64'(un0),   64'(m_un));
    check("reg.data_out",     64'(dout0), 64'(m_dreg));
    check("fwft.count",       64'(cnt1),  64'(n));
    check("fwft.full",        64'(full1), 64'(n == DEPTH));
    check("fwft.empty",       64'(empty1), 64'(n == 0));
    check("fwft.almost_full", 64'(af1),   64'(n >= AFT));
    check("fwft.almost_empty",64'(ae1),   64'(n <= AET));
    check("fwft.overflow",    64'(ov1),   64'(m_ov));
    check("fwft.underflow",   64'(un1),   64'(m_un));
    if (n > 0) check("fwft.data_out", 64'(dout1), 64'(q[0]));
  endtask

  // Drive one cycle, advance the model at the edge, compare 1 time unit later.
  task automatic step(input logic w, input logic r, input logic c,
                      input logic rs, input logic [DW-1:0] d);
    wr_en = w; rd_en = r; err_clr = c; reset = rs; data_in = d;
    @(posedge clock);
    model_edge(w, r, c, rs, d);
    #1;
    compare_all();
  endtask

  typedef struct {
    logic          w, r, c;
    logic [DW-1:0] d;
    int            exp_cnt;
    logic [DW-1:0] exp_dout;
    logic          exp_ov, exp_un;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t v;
    logic [DW-1:0] last;

    // Directed table for the registered-output instance.
    for (int i = 0; i < 8; i++) begin
      v = '{1'b1, 1'b0, 1'b0, 32'h11 + 32'(i), i + 1, 32'h0, 1'b0, 1'b0}; tbl.push_back(v);
    end
    for (int i = 0; i < 3; i++) begin
      v = '{1'b1, 1'b0, 1'b0, 32'hAA, 8, 32'h0, 1'b1, 1'b0}; tbl.push_back(v);
    end
    v = '{1'b0, 1'b0, 1'b1, 32'h0, 8, 32'h0, 1'b0, 1'b0}; tbl.push_back(v);
    for (int i = 0; i < 8; i++) begin
      v = '{1'b0, 1'b1, 1'b0, 32'h0, 7 - i, 32'h11 + 32'(i), 1'b0, 1'b0}; tbl.push_back(v);
    end
    v = '{1'b0, 1'b1, 1'b0, 32'h0,  0, 32'h18, 1'b0, 1'b1}; tbl.push_back(v);
    v = '{1'b1, 1'b1, 1'b0, 32'h55, 1, 32'h18, 1'b0, 1'b1}; tbl.push_back(v);
    v = '{1'b0, 1'b1, 1'b1, 32'h0,  0, 32'h55, 1'b0, 1'b0}; tbl.push_back(v);

    wr_en = 0; rd_en = 0; err_clr = 0; reset = 1; data_in = '0;
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 1, '0);
    check("reset.data_out", 64'(dout0), 64'h0);
    check("reset.empty",    64'(empty0), 64'h1);

    foreach (tbl[i]) begin
      step(tbl[i].w, tbl[i].r, tbl[i].c, 1'b0, tbl[i].d);
      check($sformatf("tbl[%0d].count", i),        64'(cnt0),  64'(tbl[i].exp_cnt));
      check($sformatf("tbl[%0d].data_out", i),     64'(dout0), 64'(tbl[i].exp_dout));
      check($sformatf("tbl[%0d].overflow", i),     64'(ov0),   64'(tbl[i].exp_ov));
      check($sformatf("tbl[%0d].underflow", i),    64'(un0),   64'(tbl[i].exp_un));
      check($sformatf("tbl[%0d].full", i),         64'(full0), 64'(tbl[i].exp_cnt == DEPTH));
      check($sformatf("tbl[%0d].almost_full", i),  64'(af0),   64'(tbl[i].exp_cnt >= AFT));
      check($sformatf("tbl[%0d].almost_empty", i), 64'(ae0),   64'(tbl[i].exp_cnt <= AET));
    end

    // Full FIFO with simultaneous push/pop: 0x99 must come out last.
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 32'h31 + 32'(i));
    step(1, 1, 0, 0, 32'h99);
    check("full_rw.count",    64'(cnt0), 64'd8);
    check("full_rw.overflow", 64'(ov0),  64'h0);
    check("full_rw.data_out", 64'(dout0), 64'h31);
    last = '0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, '0);
      last = dout0;
    end
    check("full_rw.last_word", 64'(last), 64'h99);

    // FWFT: a word written to an empty FIFO appears without rd_en.
    step(1, 0, 0, 0, 32'h21);
    check("fwft.first_word", 64'(dout1), 64'h21);
    step(0, 0, 0, 0, '0);
    check("fwft.hold", 64'(dout1), 64'h21);
    step(1, 0, 0, 0, 32'h22);
    step(0, 1, 0, 0, '0);
    check("fwft.next_word", 64'(dout1), 64'h22);
    check("reg.popped_21",  64'(dout0), 64'h21);
    step(0, 1, 0, 0, '0);

    // Interleaved push/pop so pointers wrap more than twice.
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0, 32'h100 + 32'(i));
      step(0, 1, 0, 0, '0);
      check("wrap.order", 64'(dout0), 64'h100 + 64'(i));
    end

    // Mid-operation reset with five words stored.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'h60 + 32'(i));
    step(0, 1, 0, 1, '0);
    check("midrst.count",    64'(cnt0),  64'h0);
    check("midrst.data_out", 64'(dout0), 64'h0);
    step(1, 0, 0, 0, 32'h77);
    check("midrst.fwft", 64'(dout1), 64'h77);
    step(0, 1, 0, 0, '0);
    check("midrst.pop", 64'(dout0), 64'h77);

    // Randomised phases alternately biased toward filling and draining.
    for (int i = 0; i < 800; i++) begin
      int wp, rp;
      wp = ((i / 60) % 2 == 0) ? 75 : 30;
      rp = ((i / 60) % 2 == 0) ? 30 : 75;
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
           $urandom_range(0, 99) < 6,  $urandom_range(0, 299) == 0, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
